// File: rtl/cfg_stream_downsizer.sv
// Splits wide configuration beats into OUT_WIDTH-bit slices for the tile bitstream ports.
// One holding register; the next beat is taken on the cycle the last slice leaves.
module cfg_stream_downsizer #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 1,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  s_tdata,
    input  logic                 s_tvalid,
    input  logic                 s_tlast,
    output logic                 s_tready,
    output logic [OUT_WIDTH-1:0] m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    input  logic                 m_tready,
    output logic                 busy
);

    localparam int unsigned R     = IN_WIDTH / OUT_WIDTH;
    localparam int unsigned IDX_W = (R > 1) ? $clog2(R) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(R - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || R < 1) begin : g_bad_width
        $error("cfg_stream_downsizer: IN_WIDTH must be a nonzero multiple of OUT_WIDTH");
    end

    logic [IN_WIDTH-1:0] hold_data;
    logic                hold_last;
    logic                full;
    logic [IDX_W-1:0]    idx;

    logic                last_slice_c;
    logic                in_fire_c;
    logic                out_fire_c;
    logic [IDX_W-1:0]    sel_c;
    logic [IN_WIDTH-1:0] shifted_c;

    assign last_slice_c = (idx == LAST_IDX);
    assign s_tready     = !full || (m_tready && last_slice_c);
    assign in_fire_c    = s_tvalid && s_tready;
    assign out_fire_c   = full && m_tready;

    assign m_tvalid = full;
    assign busy     = full;
    assign m_tlast  = full && hold_last && last_slice_c;

    // Slice selection: MSB-first walks the held beat from the top slice down.
    always_comb begin
        sel_c     = LSB_FIRST ? idx : (LAST_IDX - idx);
        shifted_c = hold_data >> (32'(sel_c) * OUT_WIDTH);
        m_tdata   = shifted_c[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data <= '0;
            hold_last <= 1'b0;
            full      <= 1'b0;
            idx       <= '0;
        end else if (in_fire_c) begin
            hold_data <= s_tdata;
            hold_last <= s_tlast;
            full      <= 1'b1;
            idx       <= '0;
        end else if (out_fire_c) begin
            if (last_slice_c) begin
                full <= 1'b0;
                idx  <= '0;
            end else begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cfg_stream_downsizer.sv
// Directed bench for cfg_stream_downsizer: 8->1 LSB-first and 8->2 MSB-first instances.
module tb_cfg_stream_downsizer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       m_tready;

    logic       s_tready, m_tdata, m_tvalid, m_tlast, busy;
    logic       s2_tready, m2_tvalid, m2_tlast, busy2;
    logic [1:0] m2_tdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cfg_stream_downsizer #(.IN_WIDTH(8), .OUT_WIDTH(1), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
        .busy(busy)
    );

    cfg_stream_downsizer #(.IN_WIDTH(8), .OUT_WIDTH(2), .LSB_FIRST(1'b0)) dut2 (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s2_tready),
        .m_tdata(m2_tdata), .m_tvalid(m2_tvalid), .m_tlast(m2_tlast), .m_tready(m_tready),
        .busy(busy2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and leave inputs safe to change; outputs are sampled at negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        logic [7:0] beats [3];
        logic [1:0] exp2  [4];
        int         k;
        int         budget;
        int         nlast;

        rst      = 1'b1;
        s_tdata  = 8'hFF;
        s_tvalid = 1'b1;
        s_tlast  = 1'b1;
        m_tready = 1'b0;

        // Reset held 2 cycles with s_tvalid high: nothing captured.
        tick();
        sample();
        check("rst_tvalid_c1", 32'(m_tvalid), 32'd0);
        check("rst_busy_c1", 32'(busy), 32'd0);
        tick();
        sample();
        check("rst_tvalid_c2", 32'(m_tvalid), 32'd0);
        check("rst_tlast_c2", 32'(m_tlast), 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        s_tvalid = 1'b0;
        sample();
        check("post_rst_tready", 32'(s_tready), 32'd1);
        check("post_rst_tvalid", 32'(m_tvalid), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_tdata", 32'(m_tdata), 32'd0);
        tick();
        sample();
        check("post_rst_nocapture", 32'(m_tvalid), 32'd0);

        // Single beat A5 -> 1,0,1,0,0,1,0,1.
        m_tready = 1'b1;
        b = 8'hA5;
        send_beat(b, 1'b1);
        for (int i = 0; i < 8; i++) begin
            sample();
            check($sformatf("a5_valid%0d", i), 32'(m_tvalid), 32'd1);
            check($sformatf("a5_busy%0d", i), 32'(busy), 32'd1);
            check($sformatf("a5_data%0d", i), 32'(m_tdata), 32'(b[i]));
            check($sformatf("a5_last%0d", i), 32'(m_tlast), 32'(i == 7));
            check($sformatf("a5_sready%0d", i), 32'(s_tready), 32'(i == 7));
            tick();
        end
        sample();
        check("a5_idle", 32'(m_tvalid), 32'd0);
        check("a5_idle_busy", 32'(busy), 32'd0);

        // Streaming 01, 80, FF with s_tvalid held: 24 slices, no bubble.
        beats[0] = 8'h01;
        beats[1] = 8'h80;
        beats[2] = 8'hFF;
        s_tdata  = beats[0];
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        tick();
        s_tdata = beats[1];
        nlast   = 0;
        for (int s = 0; s < 24; s++) begin
            sample();
            b = beats[s / 8];
            check($sformatf("stream_valid%0d", s), 32'(m_tvalid), 32'd1);
            check($sformatf("stream_data%0d", s), 32'(m_tdata), 32'(b[s % 8]));
            check($sformatf("stream_last%0d", s), 32'(m_tlast), 32'(s == 23));
            check($sformatf("stream_sready%0d", s), 32'(s_tready), 32'((s % 8) == 7));
            if (m_tlast) nlast++;
            tick();
            if (s == 7) begin
                s_tdata = beats[2];
                s_tlast = 1'b1;
            end
            if (s == 15) s_tvalid = 1'b0;
        end
        sample();
        check("stream_nlast", 32'(nlast), 32'd1);
        check("stream_idle", 32'(m_tvalid), 32'd0);

        // Backpressure on 3C: each slice stays put until taken.
        b = 8'h3C;
        m_tready = 1'b0;
        send_beat(b, 1'b1);
        k = 0;
        budget = 0;
        while (k < 8 && budget < 200) begin
            m_tready = 1'(($urandom % 2));
            sample();
            check($sformatf("bp_valid%0d", k), 32'(m_tvalid), 32'd1);
            check($sformatf("bp_data%0d", k), 32'(m_tdata), 32'(b[k]));
            check($sformatf("bp_last%0d", k), 32'(m_tlast), 32'(k == 7));
            if (m_tready) k++;
            tick();
            budget++;
        end
        check("bp_budget", 32'(k), 32'd8);
        m_tready = 1'b1;
        sample();
        check("bp_idle", 32'(m_tvalid), 32'd0);

        // MSB-first, 2-bit slices: B4 -> 10,11,01,00.
        do_reset(1);
        exp2[0] = 2'b10;
        exp2[1] = 2'b11;
        exp2[2] = 2'b01;
        exp2[3] = 2'b00;
        send_beat(8'hB4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            sample();
            check($sformatf("msb_valid%0d", i), 32'(m2_tvalid), 32'd1);
            check($sformatf("msb_data%0d", i), 32'(m2_tdata), 32'(exp2[i]));
            check($sformatf("msb_last%0d", i), 32'(m2_tlast), 32'(i == 3));
            check($sformatf("msb_sready%0d", i), 32'(s2_tready), 32'(i == 3));
            tick();
        end
        sample();
        check("msb_idle", 32'(m2_tvalid), 32'd0);

        // Reset after the 3rd slice of FF/tlast: beat dropped, next beat clean.
        do_reset(1);
        send_beat(8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            sample();
            check($sformatf("mid_data%0d", i), 32'(m_tdata), 32'd1);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            sample();
            check($sformatf("mid_dead_valid%0d", i), 32'(m_tvalid), 32'd0);
            check($sformatf("mid_dead_last%0d", i), 32'(m_tlast), 32'd0);
            tick();
        end
        send_beat(8'h00, 1'b1);
        for (int i = 0; i < 8; i++) begin
            sample();
            check($sformatf("mid_next_valid%0d", i), 32'(m_tvalid), 32'd1);
            check($sformatf("mid_next_data%0d", i), 32'(m_tdata), 32'd0);
            check($sformatf("mid_next_last%0d", i), 32'(m_tlast), 32'(i == 7));
            tick();
        end
        sample();
        check("mid_next_idle", 32'(m_tvalid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
